// File: rtl/ex_mem_flag_reg_if.sv
// ex_mem_flag_reg_if: EX->MEM boundary bundle.
// master = upstream/downstream pipeline logic, slave = the EX/MEM register.
interface ex_mem_flag_reg_if #(
   parameter int DW = 16,
   parameter int RW = 4
);
   // pipeline control
   logic          stall;
   logic          flush;
   // EX side
   logic          ex_valid;
   logic [3:0]    ex_op;
   logic [DW-1:0] ex_result;
   logic          ex_ovf;
   logic [RW-1:0] ex_rd;
   logic          ex_we;
   logic          ex_mem_rd;
   logic          ex_mem_wr;
   logic [DW-1:0] ex_store_data;
   // MEM side
   logic          mem_valid;
   logic [DW-1:0] mem_result;
   logic [RW-1:0] mem_rd;
   logic          mem_we;
   logic          mem_mem_rd;
   logic          mem_mem_wr;
   logic [DW-1:0] mem_store_data;
   logic          mem_halt;
   // architectural flags
   logic          flag_z;
   logic          flag_v;
   logic          flag_n;

   modport master (
      output stall, flush, ex_valid, ex_op, ex_result, ex_ovf, ex_rd, ex_we,
             ex_mem_rd, ex_mem_wr, ex_store_data,
      input  mem_valid, mem_result, mem_rd, mem_we, mem_mem_rd, mem_mem_wr,
             mem_store_data, mem_halt, flag_z, flag_v, flag_n
   );

   modport slave (
      input  stall, flush, ex_valid, ex_op, ex_result, ex_ovf, ex_rd, ex_we,
             ex_mem_rd, ex_mem_wr, ex_store_data,
      output mem_valid, mem_result, mem_rd, mem_we, mem_mem_rd, mem_mem_wr,
             mem_store_data, mem_halt, flag_z, flag_v, flag_n
   );
endinterface

// File: rtl/ex_mem_flag_reg.sv
// ex_mem_flag_reg: EX->MEM pipeline register that also owns the Z/V/N flags
// and the sticky halt state. Edge priority: flush > stall > capture.
// Optional build macro FLAG_BYPASS_EN: forward the flag values the next
// capture edge will write straight to flag_z/flag_v/flag_n.
module ex_mem_flag_reg #(
   parameter int DW = 16,
   parameter int RW = 4
) (
   input logic               clk,
   input logic               rst_n,
   ex_mem_flag_reg_if.slave  bus
);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_XOR = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_SRA = 4'b0101;
   localparam logic [3:0] OP_ROR = 4'b0110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   typedef enum logic {RUN, HALTED} state_t;

   state_t        state_reg;
   logic          valid_reg;
   logic [DW-1:0] result_reg;
   logic [RW-1:0] rd_reg;
   logic          we_reg;
   logic          mem_rd_reg;
   logic          mem_wr_reg;
   logic [DW-1:0] store_data_reg;
   logic          halt_reg;
   logic          z_reg;
   logic          v_reg;
   logic          n_reg;

   logic          accept;      // capture edge would take a real instruction
   logic          op_zvn;      // op writes Z, V and N
   logic          op_z;        // op writes Z only
   logic          flag_upd;    // next edge writes the flags
   logic          z_next;
   logic          v_next;
   logic          n_next;

   // Decode the flag behaviour of the incoming op and the would-be flag values.
   always_comb begin
      accept   = bus.ex_valid && (state_reg == RUN);
      op_zvn   = (bus.ex_op == OP_ADD) || (bus.ex_op == OP_SUB);
      op_z     = (bus.ex_op == OP_XOR) || (bus.ex_op == OP_SLL) ||
                 (bus.ex_op == OP_SRA) || (bus.ex_op == OP_ROR);
      flag_upd = accept && !bus.stall && !bus.flush && (op_zvn || op_z);
      z_next   = z_reg;
      v_next   = v_reg;
      n_next   = n_reg;
      if (op_zvn || op_z) begin
         z_next = (bus.ex_result == '0);
      end
      if (op_zvn) begin
         v_next = bus.ex_ovf;
         n_next = bus.ex_result[DW-1];
      end
   end

   // Pipeline register, flag register and halt FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= RUN;
         valid_reg      <= 1'b0;
         result_reg     <= '0;
         rd_reg         <= '0;
         we_reg         <= 1'b0;
         mem_rd_reg     <= 1'b0;
         mem_wr_reg     <= 1'b0;
         store_data_reg <= '0;
         halt_reg       <= 1'b0;
         z_reg          <= 1'b0;
         v_reg          <= 1'b0;
         n_reg          <= 1'b0;
      end else if (bus.flush) begin
         // Bubble: kill valid and side-effecting controls; data is don't-care.
         valid_reg      <= 1'b0;
         we_reg         <= 1'b0;
         mem_rd_reg     <= 1'b0;
         mem_wr_reg     <= 1'b0;
         result_reg     <= bus.ex_result;
         rd_reg         <= bus.ex_rd;
         store_data_reg <= bus.ex_store_data;
      end else if (!bus.stall) begin
         valid_reg      <= accept;
         result_reg     <= bus.ex_result;
         rd_reg         <= bus.ex_rd;
         store_data_reg <= bus.ex_store_data;
         we_reg         <= bus.ex_we && accept;
         mem_rd_reg     <= bus.ex_mem_rd && accept;
         mem_wr_reg     <= bus.ex_mem_wr && accept;
         if (flag_upd) begin
            z_reg <= z_next;
            v_reg <= v_next;
            n_reg <= n_next;
         end
         if (accept && (bus.ex_op == OP_HLT)) begin
            state_reg <= HALTED;
            halt_reg  <= 1'b1;
         end
      end
   end

   assign bus.mem_valid      = valid_reg;
   assign bus.mem_result     = result_reg;
   assign bus.mem_rd         = rd_reg;
   assign bus.mem_we         = we_reg;
   assign bus.mem_mem_rd     = mem_rd_reg;
   assign bus.mem_mem_wr     = mem_wr_reg;
   assign bus.mem_store_data = store_data_reg;
   assign bus.mem_halt       = halt_reg;

`ifdef FLAG_BYPASS_EN
   // Forward the pending flag write so a trailing branch needs no bubble.
   assign bus.flag_z = flag_upd ? z_next : z_reg;
   assign bus.flag_v = flag_upd ? v_next : v_reg;
   assign bus.flag_n = flag_upd ? n_next : n_reg;
`else
   assign bus.flag_z = z_reg;
   assign bus.flag_v = v_reg;
   assign bus.flag_n = n_reg;
`endif

endmodule

// File: tb/tb_ex_mem_flag_reg.sv
// tb_ex_mem_flag_reg: directed + randomized checks against a rule-level model.
module tb_ex_mem_flag_reg;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   ex_mem_flag_reg_if #(.DW(16), .RW(4)) bus ();

   ex_mem_flag_reg #(.DW(16), .RW(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // reference model state (what MEM should show)
   logic        m_halted;
   logic        e_valid, e_we, e_mrd, e_mwr, e_halt, e_z, e_v, e_n;
   logic [15:0] e_result, e_sd;
   logic [3:0]  e_rd;
   logic        data_known;

   function automatic logic sets_zvn(input logic [3:0] op);
      return (op == 4'd0) || (op == 4'd1);
   endfunction

   function automatic logic sets_z(input logic [3:0] op);
      return sets_zvn(op) || (op == 4'd2) || (op == 4'd4) || (op == 4'd5) || (op == 4'd6);
   endfunction

   task automatic model_reset();
      m_halted = 0; e_valid = 0; e_we = 0; e_mrd = 0; e_mwr = 0; e_halt = 0;
      e_z = 0; e_v = 0; e_n = 0; e_result = 0; e_sd = 0; e_rd = 0; data_known = 1;
   endtask

   task automatic model_edge();
      logic ok;
      if (bus.flush) begin
         e_valid = 0; e_we = 0; e_mrd = 0; e_mwr = 0; data_known = 0;
      end else if (!bus.stall) begin
         ok = bus.ex_valid && !m_halted;
         e_valid = ok;
         e_result = bus.ex_result; e_rd = bus.ex_rd; e_sd = bus.ex_store_data;
         data_known = 1;
         e_we = bus.ex_we && ok; e_mrd = bus.ex_mem_rd && ok; e_mwr = bus.ex_mem_wr && ok;
         if (ok && sets_z(bus.ex_op)) e_z = (bus.ex_result == 16'h0);
         if (ok && sets_zvn(bus.ex_op)) begin
            e_v = bus.ex_ovf; e_n = bus.ex_result[15];
         end
         if (ok && bus.ex_op == 4'hF) begin
            m_halted = 1; e_halt = 1;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // compare every visible output with the model
   task automatic check_all(input string tag);
      logic vz, vv, vn;
      vz = e_z; vv = e_v; vn = e_n;
`ifdef FLAG_BYPASS_EN
      if (bus.ex_valid && !bus.stall && !bus.flush && !m_halted && sets_z(bus.ex_op)) begin
         vz = (bus.ex_result == 16'h0);
         if (sets_zvn(bus.ex_op)) begin
            vv = bus.ex_ovf; vn = bus.ex_result[15];
         end
      end
`endif
      chk({tag, ".ctl"}, {27'd0, bus.mem_valid, bus.mem_we, bus.mem_mem_rd, bus.mem_mem_wr, bus.mem_halt},
          {27'd0, e_valid, e_we, e_mrd, e_mwr, e_halt});
      chk({tag, ".flags"}, {29'd0, bus.flag_z, bus.flag_v, bus.flag_n}, {29'd0, vz, vv, vn});
      if (data_known) begin
         chk({tag, ".result"}, {16'd0, bus.mem_result}, {16'd0, e_result});
         chk({tag, ".rd_sd"}, {12'd0, bus.mem_rd, bus.mem_store_data}, {12'd0, e_rd, e_sd});
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                        input logic ovf, input logic [3:0] rd, input logic we,
                        input logic mrd, input logic mwr, input logic [15:0] sd,
                        input logic st, input logic fl);
      bus.ex_valid = v; bus.ex_op = op; bus.ex_result = res; bus.ex_ovf = ovf;
      bus.ex_rd = rd; bus.ex_we = we; bus.ex_mem_rd = mrd; bus.ex_mem_wr = mwr;
      bus.ex_store_data = sd; bus.stall = st; bus.flush = fl;
   endtask

   // inputs already driven: check pre-edge view, advance model, take the edge
   task automatic step(input string tag);
      #1;
      check_all(tag);
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_drive(input bit allow_hlt);
      logic [3:0]  op;
      logic [15:0] res;
      op  = allow_hlt && ($urandom_range(0, 19) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      res = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      drive($urandom_range(0, 4) != 0, op, res, 1'($urandom), 4'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 16'($urandom),
            $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
   endtask

   initial begin
      drive(1, 4'h0, 16'h1234, 0, 4'h1, 1, 0, 0, 16'h5555, 0, 0);
      // asynchronous reset mid-cycle, no clock edge
      #2 rst_n = 0;
      model_reset();
      #1 check_all("reset_async");
      @(posedge clk); #1;
      rst_n = 1;

      // ADD 7FFF with overflow
      drive(1, 4'h0, 16'h7FFF, 1, 4'h2, 1, 0, 0, 16'h0, 0, 0);
      step("add_ovf_pre");
      drive(0, 4'h0, 16'h0, 0, 4'h0, 0, 0, 0, 16'h0, 0, 0);
      #1;
      chk("add_ovf.v", {31'd0, bus.flag_v}, 32'd1);
      chk("add_ovf.result", {16'd0, bus.mem_result}, 32'h7FFF);
      check_all("add_ovf");
      model_edge(); @(posedge clk); #1;

      // SUB zero then XOR 8000
      drive(1, 4'h1, 16'h0000, 0, 4'h2, 1, 0, 0, 16'h0, 0, 0);
      step("sub0_pre");
      drive(1, 4'h2, 16'h8000, 1, 4'h2, 1, 0, 0, 16'h0, 0, 0);
      #1;
      chk("sub0.zvn_reg", {29'd0, dut.z_reg, dut.v_reg, dut.n_reg}, 32'b100);
      check_all("sub0");
      model_edge(); @(posedge clk); #1;
      drive(0, 4'h0, 16'h1, 0, 4'h0, 0, 0, 0, 16'h0, 0, 0);
      step("xor8000");

      // LW then 3-cycle stall with changing EX values
      drive(1, 4'h8, 16'h0040, 0, 4'h3, 1, 1, 0, 16'h0, 0, 0);
      step("lw_cap");
      for (int i = 0; i < 3; i++) begin
         drive(1, 4'h0, 16'(i * 7), 1, 4'(i + 5), 1, 0, 1, 16'hABCD, 1, 0);
         #1;
         chk("lw_hold.rd", {28'd0, bus.mem_rd}, 32'h3);
         chk("lw_hold.mrd", {31'd0, bus.mem_mem_rd}, 32'd1);
         check_all("lw_hold");
         model_edge(); @(posedge clk); #1;
      end

      // flush + stall with a valid ADD
      drive(1, 4'h0, 16'h0000, 1, 4'h4, 1, 0, 0, 16'h0, 1, 1);
      step("flush_stall_pre");
      drive(0, 4'h0, 16'h0, 0, 4'h0, 0, 0, 0, 16'h0, 0, 0);
      step("flush_stall");

      // randomized run without HLT
      for (int i = 0; i < 300; i++) begin
         rand_drive(0);
         step("rand");
      end

      // HLT then ADD with write-enable
      drive(1, 4'hF, 16'h0, 0, 4'h0, 0, 0, 0, 16'h0, 0, 0);
      step("hlt_pre");
      drive(1, 4'h0, 16'h0000, 1, 4'h6, 1, 0, 0, 16'h0, 0, 0);
      #1;
      chk("hlt.halt", {31'd0, bus.mem_halt}, 32'd1);
      chk("hlt.valid", {31'd0, bus.mem_valid}, 32'd1);
      check_all("hlt");
      model_edge(); @(posedge clk); #1;
      for (int i = 0; i < 20; i++) begin
         rand_drive(0);
         step("halted_rand");
      end
      chk("halted.we", {30'd0, bus.mem_halt, bus.mem_we}, 32'b10);

      // reset while halted, mid-cycle
      rst_n = 0;
      model_reset();
      #1 check_all("reset_halted");
      @(posedge clk); #1;
      rst_n = 1;

      // randomized run that may halt
      for (int i = 0; i < 300; i++) begin
         rand_drive(1);
         step("rand_hlt");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
